// File: rtl/ltpi_csr_selftest_runner.sv
// In-system CSR self-test runner: walks a descriptor ROM, drives an Avalon-MM master,
// masks/compares read data and reports aggregate pass / fail statistics for the run.
module ltpi_csr_selftest_runner #(
   parameter  int NUM_TESTS   = 8,
   parameter  int ADDR_W      = 16,
   parameter  int DATA_W      = 32,
   parameter  int TIMEOUT_CYC = 256,
   parameter  int POLL_MAX    = 16,
   localparam int IDX_W       = $clog2(NUM_TESTS + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   output logic [IDX_W-1:0]  tv_index,
   input  logic [1:0]        tv_op,
   input  logic [ADDR_W-1:0] tv_addr,
   input  logic [DATA_W-1:0] tv_data,
   input  logic [DATA_W-1:0] tv_mask,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid,
   input  logic              avm_waitrequest,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [IDX_W-1:0]  fail_count,
   output logic [IDX_W-1:0]  first_fail_idx,
   output logic              timeout_seen
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int PC_W  = $clog2(POLL_MAX + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);
   localparam logic [IDX_W-1:0] NONE_IDX = IDX_W'(NUM_TESTS);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(TIMEOUT_CYC);
   localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(POLL_MAX - 1);

   typedef enum logic [1:0] {
      OP_NOP      = 2'b00,
      OP_WRITE    = 2'b01,
      OP_READ_CMP = 2'b10,
      OP_POLL     = 2'b11
   } op_e;

   typedef struct packed {
      op_e               op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] mask;
   } desc_t;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_WR, S_RD, S_RWAIT, S_NEXT, S_DONE
   } state_e;

   state_e           state, state_nxt;
   desc_t            desc;
   logic [IDX_W-1:0] idx;
   logic [TMR_W-1:0] timer;
   logic [PC_W-1:0]  poll_cnt;

   logic run_start, fail_evt, to_evt, timer_clr, poll_clr, poll_inc;
   logic idx_inc, finish, finish_ok, rd_match, tmr_exp;

   assign busy          = (state != S_IDLE) && (state != S_DONE);
   assign done          = (state == S_DONE);
   assign avm_write     = (state == S_WR);
   assign avm_read      = (state == S_RD);
   assign avm_address   = desc.addr;
   assign avm_writedata = desc.data;
   assign tv_index      = idx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      run_start = 1'b0;
      fail_evt  = 1'b0;
      to_evt    = 1'b0;
      timer_clr = 1'b0;
      poll_clr  = 1'b0;
      poll_inc  = 1'b0;
      idx_inc   = 1'b0;
      finish    = 1'b0;
      finish_ok = 1'b0;
      rd_match  = ((avm_readdata ^ desc.data) & desc.mask) == '0;
      // timer keeps running from RD into RWAIT, so use >= rather than ==
      tmr_exp   = (timer >= TMR_LAST);
      case (state)
         S_IDLE: if (start && !abort) begin
            state_nxt = S_FETCH;
            run_start = 1'b1;
         end
         S_FETCH: state_nxt = S_LOAD;
         S_LOAD: begin
            case (op_e'(tv_op))
               OP_NOP:   state_nxt = S_NEXT;
               OP_WRITE: begin
                  state_nxt = S_WR;
                  timer_clr = 1'b1;
               end
               default: begin
                  state_nxt = S_RD;
                  timer_clr = 1'b1;
                  poll_clr  = 1'b1;
               end
            endcase
         end
         S_WR: begin
            if (!avm_waitrequest) state_nxt = S_NEXT;
            else if (tmr_exp) begin
               state_nxt = S_NEXT;
               to_evt    = 1'b1;
               fail_evt  = 1'b1;
            end
         end
         S_RD: begin
            if (!avm_waitrequest) state_nxt = S_RWAIT;
            else if (tmr_exp) begin
               state_nxt = S_NEXT;
               to_evt    = 1'b1;
               fail_evt  = 1'b1;
            end
         end
         S_RWAIT: begin
            if (avm_readdatavalid) begin
               if (rd_match) state_nxt = S_NEXT;
               else if (desc.op == OP_READ_CMP || poll_cnt == PC_LAST) begin
                  state_nxt = S_NEXT;
                  fail_evt  = 1'b1;
               end else begin
                  state_nxt = S_RD;
                  poll_inc  = 1'b1;
                  timer_clr = 1'b1;
               end
            end else if (tmr_exp) begin
               state_nxt = S_NEXT;
               to_evt    = 1'b1;
               fail_evt  = 1'b1;
            end
         end
         S_NEXT: begin
            if (idx == LAST_IDX) begin
               state_nxt = S_DONE;
               finish    = 1'b1;
               finish_ok = (fail_count == '0);
            end else begin
               state_nxt = S_FETCH;
               idx_inc   = 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // abort wins over any completion or failure decided this cycle
      if (abort && busy) begin
         state_nxt = S_DONE;
         fail_evt  = 1'b0;
         to_evt    = 1'b0;
         idx_inc   = 1'b0;
         poll_inc  = 1'b0;
         finish    = 1'b1;
         finish_ok = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         desc     <= '0;
         timer    <= '0;
         poll_cnt <= '0;
      end else begin
         if (state == S_LOAD) desc <= '{op: op_e'(tv_op), addr: tv_addr, data: tv_data, mask: tv_mask};
         if (timer_clr) timer <= '0;
         else if ((state == S_WR || state == S_RD || state == S_RWAIT) && timer != TMR_SAT)
            timer <= timer + TMR_W'(1);
         if (poll_clr)      poll_cnt <= '0;
         else if (poll_inc) poll_cnt <= poll_cnt + PC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx            <= '0;
         fail_count     <= '0;
         first_fail_idx <= NONE_IDX;
         timeout_seen   <= 1'b0;
         pass           <= 1'b0;
      end else begin
         if (run_start) begin
            idx            <= '0;
            fail_count     <= '0;
            first_fail_idx <= NONE_IDX;
            timeout_seen   <= 1'b0;
            pass           <= 1'b0;
         end
         if (idx_inc) idx <= idx + IDX_W'(1);
         if (fail_evt) begin
            if (fail_count != NONE_IDX)     fail_count     <= fail_count + IDX_W'(1);
            if (first_fail_idx == NONE_IDX) first_fail_idx <= idx;
         end
         if (to_evt) timeout_seen <= 1'b1;
         if (finish) pass <= finish_ok;
      end
   end

endmodule

// File: tb/tb_ltpi_csr_selftest_runner.sv
// Bench for ltpi_csr_selftest_runner: descriptor ROM and Avalon-MM slave models, directed
// scenarios plus randomized runs checked against a sequential descriptor-level model.
module tb_ltpi_csr_selftest_runner;
   localparam int NT = 8;
   localparam int IW = 4;

   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [IW-1:0] tv_index, fail_count, first_fail_idx;
   logic [1:0]  tv_op = '0;
   logic [15:0] tv_addr = '0, avm_address;
   logic [31:0] tv_data = '0, tv_mask = '0, avm_writedata, avm_readdata = '0;
   logic        avm_read, avm_write, avm_readdatavalid = 1'b0, avm_waitrequest;
   logic        busy, done, pass, timeout_seen;

   ltpi_csr_selftest_runner #(.NUM_TESTS(NT), .ADDR_W(16), .DATA_W(32), .TIMEOUT_CYC(256), .POLL_MAX(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .tv_index(tv_index), .tv_op(tv_op), .tv_addr(tv_addr), .tv_data(tv_data), .tv_mask(tv_mask),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
      .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
      .first_fail_idx(first_fail_idx), .timeout_seen(timeout_seen));

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   // descriptor ROM, one cycle of read latency
   logic [1:0]  rom_op   [NT];
   logic [15:0] rom_addr [NT];
   logic [31:0] rom_data [NT];
   logic [31:0] rom_mask [NT];
   always @(posedge clk) begin
      if (tv_index < IW'(NT)) begin
         tv_op   <= rom_op[tv_index[2:0]];
         tv_addr <= rom_addr[tv_index[2:0]];
         tv_data <= rom_data[tv_index[2:0]];
         tv_mask <= rom_mask[tv_index[2:0]];
      end else tv_op <= 2'b00;
   end

   // Avalon-MM slave: echo memory, fixed readback, or poll pattern; optional stalls/hangs
   bit   rand_ws = 0, hang_wr = 0, rd_drop = 0, mem_load = 0, rd_pend = 0;
   logic [15:0] drop_addr = '0;
   int   rd_mode = 0, poll_zero = 0, poll_base = 0, wait_cnt = 0, rd_lat = 0;
   int   rd_accepts = 0, wr_accepts = 0, done_cnt = 0, overlap_cnt = 0;
   logic [31:0] rd_fixed = '0, rd_data = '0;
   logic [31:0] mem [16];
   logic [31:0] mem_init [16];
   logic [1:0]  r_pass_dummy;

   assign avm_waitrequest = (avm_write && hang_wr) || (wait_cnt != 0);

   always @(posedge clk) begin
      avm_readdatavalid <= 1'b0;
      if (mem_load) for (int i = 0; i < 16; i++) mem[i] <= mem_init[i];
      if ((avm_read || avm_write) && wait_cnt != 0) wait_cnt <= wait_cnt - 1;
      if (avm_write && !avm_waitrequest) begin
         mem[avm_address[3:0]] <= avm_writedata;
         wr_accepts <= wr_accepts + 1;
         wait_cnt   <= rand_ws ? int'($urandom_range(0, 3)) : 0;
      end
      if (avm_read && !avm_waitrequest) begin
         rd_accepts <= rd_accepts + 1;
         wait_cnt   <= rand_ws ? int'($urandom_range(0, 3)) : 0;
         if (!(rd_drop && avm_address == drop_addr)) begin
            rd_pend <= 1'b1;
            rd_lat  <= rand_ws ? int'($urandom_range(0, 2)) : 0;
            case (rd_mode)
               1:       rd_data <= rd_fixed;
               2:       rd_data <= (rd_accepts - poll_base >= poll_zero) ? 32'h1 : 32'h0;
               default: rd_data <= mem[avm_address[3:0]];
            endcase
         end
      end else if (rd_pend) begin
         if (rd_lat == 0) begin
            avm_readdatavalid <= 1'b1;
            avm_readdata      <= rd_data;
            rd_pend           <= 1'b0;
         end else rd_lat <= rd_lat - 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (avm_read && avm_write) overlap_cnt <= overlap_cnt + 1;
   end

   logic          r_pass, r_to;
   logic [IW-1:0] r_fc, r_ffi;

   task automatic clear_rom();
      for (int i = 0; i < NT; i++) begin
         rom_op[i] = 2'b00; rom_addr[i] = '0; rom_data[i] = '0; rom_mask[i] = '0;
      end
   endtask

   task automatic set_rom(input int i, input logic [1:0] op, input logic [15:0] a,
                          input logic [31:0] d, input logic [31:0] m);
      rom_op[i] = op; rom_addr[i] = a; rom_data[i] = d; rom_mask[i] = m;
   endtask

   task automatic load_mem();
      mem_load = 1; @(negedge clk); mem_load = 0;
   endtask

   // pulse start at a negedge, wait (bounded) for done and capture the result outputs
   task automatic run_dut(input int limit, output bit timed_out);
      start = 1; @(negedge clk); start = 0;
      timed_out = 1;
      for (int c = 0; c < limit; c++) begin
         if (done) begin
            timed_out = 0;
            r_pass = pass; r_fc = fail_count; r_ffi = first_fail_idx; r_to = timeout_seen;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 0;
      repeat (2) @(negedge clk);
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %0b exp 0", done); else n_pass++;
      n_chk++; if (pass !== 1'b0) $display("FAIL reset_pass got %0b exp 0", pass); else n_pass++;
      n_chk++; if (fail_count !== 4'd0) $display("FAIL reset_fail_count got %0d exp 0", fail_count); else n_pass++;
      n_chk++; if (first_fail_idx !== 4'd8) $display("FAIL reset_first_fail got %0d exp 8", first_fail_idx); else n_pass++;
      n_chk++; if (timeout_seen !== 1'b0) $display("FAIL reset_timeout got %0b exp 0", timeout_seen); else n_pass++;
      n_chk++; if ({avm_read, avm_write} !== 2'b00) $display("FAIL reset_strobes got %b exp 00", {avm_read, avm_write}); else n_pass++;
      n_chk++; if (tv_index !== 4'd0 || avm_address !== 16'h0) $display("FAIL reset_index_addr got %0d/%0h exp 0/0", tv_index, avm_address); else n_pass++;
      reset_n = 1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bit to;
      clear_rom(); rd_mode = 0;
      set_rom(0, 2'b01, 16'h10, 32'hA5A5_0001, 32'h0);
      set_rom(1, 2'b10, 16'h10, 32'hA5A5_0001, 32'hFFFF_FFFF);
      run_dut(2000, to);
      n_chk++; if (to) $display("FAIL basic_done got timeout exp done"); else n_pass++;
      n_chk++; if (r_pass !== 1'b1) $display("FAIL basic_pass got %0b exp 1", r_pass); else n_pass++;
      n_chk++; if (r_fc !== 4'd0) $display("FAIL basic_fail_count got %0d exp 0", r_fc); else n_pass++;
      n_chk++; if (r_ffi !== 4'd8) $display("FAIL basic_first_fail got %0d exp 8", r_ffi); else n_pass++;
      n_chk++; if (pass !== 1'b1 || busy !== 1'b0) $display("FAIL basic_sticky got pass=%0b busy=%0b exp 1/0", pass, busy); else n_pass++;
   endtask

   task automatic test_mask();
      bit to;
      clear_rom(); rd_mode = 1; rd_fixed = 32'h0000_00F1;
      set_rom(2, 2'b10, 16'h10, 32'h0000_00F0, 32'hFFFF_FFFE);
      run_dut(2000, to);
      n_chk++; if (to || r_pass !== 1'b1 || r_fc !== 4'd0) $display("FAIL mask_ignore got to=%0b pass=%0b fc=%0d exp 0/1/0", to, r_pass, r_fc); else n_pass++;
      set_rom(2, 2'b10, 16'h10, 32'h0000_00F0, 32'hFFFF_FFFF);
      run_dut(2000, to);
      n_chk++; if (to) $display("FAIL mask_full_done got timeout exp done"); else n_pass++;
      n_chk++; if (r_fc !== 4'd1) $display("FAIL mask_full_fail_count got %0d exp 1", r_fc); else n_pass++;
      n_chk++; if (r_ffi !== 4'd2) $display("FAIL mask_full_first_fail got %0d exp 2", r_ffi); else n_pass++;
      n_chk++; if (r_pass !== 1'b0) $display("FAIL mask_full_pass got %0b exp 0", r_pass); else n_pass++;
      rd_mode = 0;
   endtask

   task automatic test_poll();
      bit to; int base;
      clear_rom(); rd_mode = 2;
      set_rom(0, 2'b11, 16'h4, 32'h1, 32'h1);
      poll_zero = 5; poll_base = rd_accepts; base = rd_accepts;
      run_dut(4000, to);
      n_chk++; if (rd_accepts - base != 6) $display("FAIL poll_ok_reads got %0d exp 6", rd_accepts - base); else n_pass++;
      n_chk++; if (to || r_pass !== 1'b1 || r_fc !== 4'd0) $display("FAIL poll_ok_result got to=%0b pass=%0b fc=%0d exp 0/1/0", to, r_pass, r_fc); else n_pass++;
      poll_zero = 1000; poll_base = rd_accepts; base = rd_accepts;
      run_dut(6000, to);
      n_chk++; if (rd_accepts - base != 16) $display("FAIL poll_never_reads got %0d exp 16", rd_accepts - base); else n_pass++;
      n_chk++; if (to || r_fc !== 4'd1) $display("FAIL poll_never_fail_count got to=%0b fc=%0d exp 0/1", to, r_fc); else n_pass++;
      n_chk++; if (r_pass !== 1'b0 || r_ffi !== 4'd0) $display("FAIL poll_never_result got pass=%0b ffi=%0d exp 0/0", r_pass, r_ffi); else n_pass++;
      rd_mode = 0;
   endtask

   task automatic test_timeout();
      int hi, rb; bit seen, got;
      clear_rom(); rd_mode = 0; rand_ws = 0;
      mem_init[5] = 32'h1234_5678; load_mem();
      set_rom(0, 2'b01, 16'h2, 32'hDEAD_BEEF, 32'h0);
      set_rom(1, 2'b10, 16'h5, 32'h1234_5678, 32'hFFFF_FFFF);
      hang_wr = 1; rb = rd_accepts; hi = 0; seen = 0; got = 0;
      start = 1; @(negedge clk); start = 0;
      for (int c = 0; c < 50 && !avm_write; c++) @(negedge clk);
      for (int c = 0; c < 1000 && avm_write; c++) begin hi++; @(negedge clk); end
      for (int c = 0; c < 500; c++) begin
         if (done) begin
            got = 1; r_pass = pass; r_fc = fail_count; r_ffi = first_fail_idx; r_to = timeout_seen;
            break;
         end
         @(negedge clk);
      end
      seen = got;
      n_chk++; if (hi != 256) $display("FAIL timeout_strobe_cycles got %0d exp 256", hi); else n_pass++;
      n_chk++; if (!seen) $display("FAIL timeout_done got none exp done"); else n_pass++;
      n_chk++; if (r_to !== 1'b1) $display("FAIL timeout_seen got %0b exp 1", r_to); else n_pass++;
      n_chk++; if (r_fc !== 4'd1 || r_ffi !== 4'd0) $display("FAIL timeout_stats got fc=%0d ffi=%0d exp 1/0", r_fc, r_ffi); else n_pass++;
      n_chk++; if (rd_accepts - rb != 1) $display("FAIL timeout_continues got %0d reads exp 1", rd_accepts - rb); else n_pass++;
      hang_wr = 0;
      @(negedge clk);
   endtask

   task automatic test_abort();
      int base, cmds; bit got;
      clear_rom(); rd_mode = 0; rand_ws = 0;
      for (int i = 0; i < 4; i++) begin
         mem_init[i] = $urandom;
         set_rom(i, 2'b10, 16'(i), mem_init[i], 32'hFFFF_FFFF);
      end
      load_mem();
      rd_drop = 1; drop_addr = 16'h3; base = rd_accepts; got = 0;
      start = 1; @(negedge clk); start = 0;
      for (int c = 0; c < 500 && (rd_accepts - base) < 4; c++) @(negedge clk);
      n_chk++; if (rd_accepts - base != 4 || busy !== 1'b1) $display("FAIL abort_reach_rwait got reads=%0d busy=%0b exp 4/1", rd_accepts - base, busy); else n_pass++;
      abort = 1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (done) begin got = 1; r_pass = pass; r_fc = fail_count; break; end
      end
      abort = 0;
      n_chk++; if (!got) $display("FAIL abort_done got none exp done within 2 cycles"); else n_pass++;
      n_chk++; if (r_pass !== 1'b0 || r_fc !== 4'd0) $display("FAIL abort_result got pass=%0b fc=%0d exp 0/0", r_pass, r_fc); else n_pass++;
      cmds = rd_accepts + wr_accepts;
      repeat (20) @(negedge clk);
      n_chk++; if (rd_accepts + wr_accepts != cmds || avm_read || avm_write) $display("FAIL abort_quiet got %0d cmds exp 0", rd_accepts + wr_accepts - cmds); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL abort_idle got busy=%0b exp 0", busy); else n_pass++;
      rd_drop = 0;
   endtask

   task automatic test_start_busy();
      int dc;
      clear_rom(); rd_mode = 0; rand_ws = 1;
      for (int i = 0; i < 4; i++) begin
         mem_init[i] = $urandom;
         set_rom(i, 2'b10, 16'(i), mem_init[i], 32'hFFFF_FFFF);
      end
      load_mem();
      dc = done_cnt;
      start = 1; @(negedge clk); start = 0;
      repeat (8) @(negedge clk);
      n_chk++; if (busy !== 1'b1) $display("FAIL start_busy_precond got busy=%0b exp 1", busy); else n_pass++;
      start = 1; @(negedge clk); start = 0;
      for (int c = 0; c < 2000 && !done; c++) @(negedge clk);
      repeat (30) @(negedge clk);
      n_chk++; if (done_cnt - dc != 1) $display("FAIL start_busy_runs got %0d done pulses exp 1", done_cnt - dc); else n_pass++;
      n_chk++; if (busy !== 1'b0 || pass !== 1'b1) $display("FAIL start_busy_result got busy=%0b pass=%0b exp 0/1", busy, pass); else n_pass++;
      start = 1; abort = 1; @(negedge clk); start = 0; abort = 0;
      repeat (3) @(negedge clk);
      n_chk++; if (busy !== 1'b0 || done_cnt - dc != 1) $display("FAIL start_abort_idle got busy=%0b pulses=%0d exp 0/1", busy, done_cnt - dc); else n_pass++;
      rand_ws = 0;
   endtask

   task automatic test_reset_mid();
      clear_rom(); hang_wr = 1;
      set_rom(0, 2'b01, 16'h1, 32'h5555_AAAA, 32'h0);
      start = 1; @(negedge clk); start = 0;
      for (int c = 0; c < 50 && !avm_write; c++) @(negedge clk);
      repeat (5) @(negedge clk);
      n_chk++; if (avm_write !== 1'b1) $display("FAIL reset_mid_precond got write=%0b exp 1", avm_write); else n_pass++;
      #2 reset_n = 0;
      #1;
      n_chk++; if (avm_write !== 1'b0 || avm_read !== 1'b0) $display("FAIL reset_mid_strobes got %b exp 00", {avm_read, avm_write}); else n_pass++;
      n_chk++; if (busy !== 1'b0 || first_fail_idx !== 4'd8) $display("FAIL reset_mid_state got busy=%0b ffi=%0d exp 0/8", busy, first_fail_idx); else n_pass++;
      @(negedge clk);
      reset_n = 1; hang_wr = 0;
      @(negedge clk);
   endtask

   // random descriptor lists against a sequential model of the memory and the compare rules
   task automatic test_random();
      logic [31:0] m [16];
      logic [1:0]  op;
      logic [15:0] a;
      logic [31:0] d, mk;
      int efc, effi, erd, ewr, rb, wb, ob;
      bit to, ok;
      rd_mode = 0; rand_ws = 1;
      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < 16; i++) begin mem_init[i] = $urandom; m[i] = mem_init[i]; end
         load_mem();
         efc = 0; effi = NT; erd = 0; ewr = 0;
         for (int i = 0; i < NT; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom_range(0, 7));
            d  = $urandom; mk = $urandom;
            case (op)
               2'b01: begin m[a[3:0]] = d; ewr++; end
               2'b10, 2'b11: begin
                  if ($urandom_range(0, 1) == 1) d = m[a[3:0]];
                  case ($urandom_range(0, 2))
                     0: mk = 32'hFFFF_FFFF;
                     1: mk = 32'h0;
                     default: ;
                  endcase
                  ok = ((m[a[3:0]] ^ d) & mk) == 32'h0;
                  erd += (op == 2'b11 && !ok) ? 16 : 1;
                  if (!ok) begin efc++; if (effi == NT) effi = i; end
               end
               default: ;
            endcase
            set_rom(i, op, a, d, mk);
         end
         rb = rd_accepts; wb = wr_accepts; ob = overlap_cnt;
         run_dut(8000, to);
         n_chk++; if (to) $display("FAIL rand%0d_done got timeout exp done", it); else n_pass++;
         n_chk++; if (r_fc !== 4'(efc)) $display("FAIL rand%0d_fail_count got %0d exp %0d", it, r_fc, efc); else n_pass++;
         n_chk++; if (r_ffi !== 4'(effi)) $display("FAIL rand%0d_first_fail got %0d exp %0d", it, r_ffi, effi); else n_pass++;
         n_chk++; if (r_pass !== (efc == 0) || r_to !== 1'b0) $display("FAIL rand%0d_pass got %0b/%0b exp %0b/0", it, r_pass, r_to, efc == 0); else n_pass++;
         n_chk++; if (rd_accepts - rb != erd || wr_accepts - wb != ewr) $display("FAIL rand%0d_bus got rd=%0d wr=%0d exp %0d/%0d", it, rd_accepts - rb, wr_accepts - wb, erd, ewr); else n_pass++;
         n_chk++; if (overlap_cnt != ob) $display("FAIL rand%0d_rw_overlap got %0d exp 0", it, overlap_cnt - ob); else n_pass++;
      end
      rand_ws = 0;
   endtask

   initial begin
      r_pass_dummy = '0;
      clear_rom();
      for (int i = 0; i < 16; i++) mem_init[i] = '0;
      @(negedge clk);
      test_reset();
      load_mem();
      test_basic();
      test_mask();
      test_poll();
      test_timeout();
      test_abort();
      test_start_busy();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
